e203_exu_oitf: RTL and testbench
================================

E203_EXU_OITF -- requirements
Module: e203_exu_oitf

Interface
REQ-001 SHALL have parameter DEPTH, default 4; entry count, power of two, 2..16.
REQ-002 SHALL have clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have dis_ena  in  1  dispatch requests allocation of a long-pipe entry.
REQ-005 SHALL have dis_ready  out  1  an entry is free (not full).
REQ-006 SHALL have disp_i_rdwen, disp_i_rdfpu  in  1 each  rd write-enable and rd-is-FPU flag of the dispatched instruction.
REQ-007 SHALL have disp_i_rdidx  in  5  rd index; disp_i_pc  in  32  PC.
REQ-008 SHALL have dis_ptr  out  5  itag given to the allocating instruction; entry index zero-extended.
REQ-009 SHALL have disp_i_rs1en, disp_i_rs2en, disp_i_rs1fpu, disp_i_rs2fpu  in  1 each; disp_i_rs1idx, disp_i_rs2idx  in  5 each  sources of the dispatching instruction.
REQ-010 SHALL have oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd  out  1 each  hazard flags.
REQ-011 SHALL have ret_ena  in  1  head entry retires (from long-pipe write-back).
REQ-012 SHALL have ret_ptr  out  5  head itag; ret_rdidx  out  5; ret_pc  out  32; ret_rdwen, ret_rdfpu  out  1 each  head fields.
REQ-013 SHALL have oitf_empty  out  1  no valid entries.

Function
REQ-014 SHALL hold per entry: vld, rdwen, rdfpu, rdidx[4:0], pc[31:0].
REQ-015 SHALL keep alc_ptr and ret_ptr of log2(DEPTH) bits, each with a wrap flag toggled on wrap DEPTH-1 -> 0.
REQ-016 SHALL set empty = (pointers equal, flags equal); full = (pointers equal, flags differ); dis_ready = ~full, no same-cycle retire bypass.
REQ-017 SHALL allocate (alc = dis_ena & dis_ready): write entry[alc_ptr] with disp_i_* fields, set vld, advance alc_ptr, at the edge.
REQ-018 SHALL retire (ret = ret_ena & ~oitf_empty): clear vld of entry[ret_ptr], advance ret_ptr, at the edge.
REQ-019 SHALL ignore dis_ena while full and ret_ena while empty; no state change, no error output.
REQ-020 SHALL allow alc and ret in one cycle; occupancy unchanged, both pointers advance.
REQ-021 SHALL drive dis_ptr = alc_ptr combinationally, valid in the cycle dis_ena is sampled.
REQ-022 SHALL drive ret_ptr/ret_rdidx/ret_pc/ret_rdwen/ret_rdfpu combinationally from entry[ret_ptr]; meaningless when oitf_empty=1.
REQ-023 SHALL assert oitfrd_match_disprsN = disp_i_rsNen & OR over entries (vld & rdwen & rdidx==disp_i_rsNidx & rdfpu==disp_i_rsNfpu).
REQ-024 SHALL assert oitfrd_match_disprd = disp_i_rdwen & OR over entries (vld & rdwen & rdidx==disp_i_rdidx & rdfpu==disp_i_rdfpu).
REQ-025 SHALL compute matches from registered state only; an entry retiring this cycle still matches, an entry allocating this cycle does not.
REQ-026 SHALL have no other latency: allocation visible to retire outputs/matches one cycle after alc.

Reset
REQ-027 SHALL, on rst=1 at any time, asynchronously clear both pointers, wrap flags, all vld and all entry fields to 0.
REQ-028 SHALL, during/after reset, output oitf_empty=1, dis_ready=1, dis_ptr=0, ret_ptr=0, ret_rdidx=0, ret_pc=0, ret_rdwen=0, ret_rdfpu=0, all match flags=0.
REQ-029 SHALL discard in-flight entries on reset mid-operation; first post-reset allocation gets itag 0.

Verification
REQ-030 SHALL test fill: DEPTH=4, four dis_ena with rdidx 1..4 -> dis_ptr 0,1,2,3; after 4th, dis_ready=0, oitf_empty=0; 5th dis_ena ignored, alc_ptr stays 0.
REQ-031 SHALL test drain and wrap: from full, four ret_ena -> ret_ptr 0,1,2,3, ret_rdidx 1..4, then oitf_empty=1; next alloc gets dis_ptr 0 with flipped wrap, empty deasserts.
REQ-032 SHALL test simultaneous events: occupancy 2, dis_ena & ret_ena same cycle -> occupancy stays 2, both pointers +1; at full, dis_ena & ret_ena -> only retire occurs.
REQ-033 SHALL test hazards: entry rdidx=5, rdwen=1, rdfpu=0; dispatch rs1idx=5, rs1en=1, rs1fpu=0 -> match_disprs1=1; rs1fpu=1 -> 0; rs1en=0 -> 0; entry rdwen=0 -> 0; in the cycle that entry retires -> still 1, next cycle 0.
REQ-034 SHALL test ret_ena while empty: no pointer change, oitf_empty stays 1.
REQ-035 SHALL test rst pulse mid-cycle with 3 entries valid -> outputs immediately per REQ-028, next allocation dis_ptr=0.

Source files
------------

// File: rtl/e203_exu_oitf.sv
// Outstanding instruction track FIFO for the long-pipe execution unit.
// Each dispatched long-pipe instruction takes one entry, which records its
// destination register, until write-back retires it. Valid entries are
// compared against the sources and destination of the instruction now
// dispatching to flag RAW and WAW hazards.
module e203_exu_oitf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        dis_ena,
  output logic        dis_ready,
  input  logic        disp_i_rdwen,
  input  logic        disp_i_rdfpu,
  input  logic [4:0]  disp_i_rdidx,
  input  logic [31:0] disp_i_pc,
  output logic [4:0]  dis_ptr,

  input  logic        disp_i_rs1en,
  input  logic        disp_i_rs2en,
  input  logic        disp_i_rs1fpu,
  input  logic        disp_i_rs2fpu,
  input  logic [4:0]  disp_i_rs1idx,
  input  logic [4:0]  disp_i_rs2idx,
  output logic        oitfrd_match_disprs1,
  output logic        oitfrd_match_disprs2,
  output logic        oitfrd_match_disprd,

  input  logic        ret_ena,
  output logic [4:0]  ret_ptr,
  output logic [4:0]  ret_rdidx,
  output logic [31:0] ret_pc,
  output logic        ret_rdwen,
  output logic        ret_rdfpu,

  output logic        oitf_empty
);

  // DEPTH is a power of two in 2..16, so the index fits in 1..4 bits
  // and the zero-extension to the 5-bit itag always has room.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

  // Entry storage
  logic [DEPTH-1:0]       vld_q,   vld_d;
  logic [DEPTH-1:0]       rdwen_q, rdwen_d;
  logic [DEPTH-1:0]       rdfpu_q, rdfpu_d;
  logic [DEPTH-1:0][4:0]  rdidx_q, rdidx_d;
  logic [DEPTH-1:0][31:0] pc_q,    pc_d;

  // Pointers with wrap flags; equal pointers mean empty when the flags
  // agree and full when they differ.
  logic [AW-1:0] alc_ptr_q, alc_ptr_d;
  logic [AW-1:0] ret_ptr_q, ret_ptr_d;
  logic          alc_flg_q, alc_flg_d;
  logic          ret_flg_q, ret_flg_d;

  logic full_s;
  logic alc_s;
  logic ret_s;
  logic hit_rs1_s;
  logic hit_rs2_s;
  logic hit_rd_s;

  assign oitf_empty = (alc_ptr_q == ret_ptr_q) & (alc_flg_q == ret_flg_q);
  assign full_s     = (alc_ptr_q == ret_ptr_q) & (alc_flg_q != ret_flg_q);
  // No bypass from a same-cycle retire: a full queue refuses dispatch.
  assign dis_ready  = ~full_s;

  assign alc_s = dis_ena & dis_ready;
  assign ret_s = ret_ena & ~oitf_empty;

  assign dis_ptr   = {{(5 - AW){1'b0}}, alc_ptr_q};
  assign ret_ptr   = {{(5 - AW){1'b0}}, ret_ptr_q};
  assign ret_rdidx = rdidx_q[ret_ptr_q];
  assign ret_pc    = pc_q[ret_ptr_q];
  assign ret_rdwen = rdwen_q[ret_ptr_q];
  assign ret_rdfpu = rdfpu_q[ret_ptr_q];

  // Next-state: retire clears the head entry, allocate fills the tail entry.
  // Both can never target the same index (that needs empty or full).
  always_comb begin
    vld_d     = vld_q;
    rdwen_d   = rdwen_q;
    rdfpu_d   = rdfpu_q;
    rdidx_d   = rdidx_q;
    pc_d      = pc_q;
    alc_ptr_d = alc_ptr_q;
    alc_flg_d = alc_flg_q;
    ret_ptr_d = ret_ptr_q;
    ret_flg_d = ret_flg_q;

    if (ret_s) begin
      vld_d[ret_ptr_q] = 1'b0;
      if (ret_ptr_q == PTR_MAX) begin
        ret_ptr_d = '0;
        ret_flg_d = ~ret_flg_q;
      end else begin
        ret_ptr_d = ret_ptr_q + AW'(1);
      end
    end else begin
      ret_ptr_d = ret_ptr_q;
    end

    if (alc_s) begin
      vld_d[alc_ptr_q]   = 1'b1;
      rdwen_d[alc_ptr_q] = disp_i_rdwen;
      rdfpu_d[alc_ptr_q] = disp_i_rdfpu;
      rdidx_d[alc_ptr_q] = disp_i_rdidx;
      pc_d[alc_ptr_q]    = disp_i_pc;
      if (alc_ptr_q == PTR_MAX) begin
        alc_ptr_d = '0;
        alc_flg_d = ~alc_flg_q;
      end else begin
        alc_ptr_d = alc_ptr_q + AW'(1);
      end
    end else begin
      alc_ptr_d = alc_ptr_q;
    end
  end

  // Hazard compare against registered entries only; an entry retiring this
  // cycle still matches, one allocating this cycle does not yet.
  always_comb begin
    hit_rs1_s = 1'b0;
    hit_rs2_s = 1'b0;
    hit_rd_s  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_rs1_s = hit_rs1_s | (vld_q[i] & rdwen_q[i] &
                  (rdidx_q[i] == disp_i_rs1idx) & (rdfpu_q[i] == disp_i_rs1fpu));
      hit_rs2_s = hit_rs2_s | (vld_q[i] & rdwen_q[i] &
                  (rdidx_q[i] == disp_i_rs2idx) & (rdfpu_q[i] == disp_i_rs2fpu));
      hit_rd_s  = hit_rd_s  | (vld_q[i] & rdwen_q[i] &
                  (rdidx_q[i] == disp_i_rdidx)  & (rdfpu_q[i] == disp_i_rdfpu));
    end
  end

  assign oitfrd_match_disprs1 = disp_i_rs1en & hit_rs1_s;
  assign oitfrd_match_disprs2 = disp_i_rs2en & hit_rs2_s;
  assign oitfrd_match_disprd  = disp_i_rdwen & hit_rd_s;

  // State registers; reset wipes pointers, flags and every entry field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      rdwen_q   <= '0;
      rdfpu_q   <= '0;
      rdidx_q   <= '0;
      pc_q      <= '0;
      alc_ptr_q <= '0;
      ret_ptr_q <= '0;
      alc_flg_q <= 1'b0;
      ret_flg_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      rdwen_q   <= rdwen_d;
      rdfpu_q   <= rdfpu_d;
      rdidx_q   <= rdidx_d;
      pc_q      <= pc_d;
      alc_ptr_q <= alc_ptr_d;
      ret_ptr_q <= ret_ptr_d;
      alc_flg_q <= alc_flg_d;
      ret_flg_q <= ret_flg_d;
    end
  end

endmodule

// File: tb/tb_e203_exu_oitf.sv
// Directed bench for e203_exu_oitf (DEPTH=4). The driver pushes hand-computed
// expected output values into a scoreboard queue each cycle; a separate
// monitor pops them on the falling edge and compares against the DUT.
module tb_e203_exu_oitf;

  logic        clk = 1'b0;
  logic        rst;
  logic        dis_ena, dis_ready;
  logic        disp_i_rdwen, disp_i_rdfpu;
  logic [4:0]  disp_i_rdidx;
  logic [31:0] disp_i_pc;
  logic [4:0]  dis_ptr;
  logic        disp_i_rs1en, disp_i_rs2en, disp_i_rs1fpu, disp_i_rs2fpu;
  logic [4:0]  disp_i_rs1idx, disp_i_rs2idx;
  logic        oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd;
  logic        ret_ena;
  logic [4:0]  ret_ptr, ret_rdidx;
  logic [31:0] ret_pc;
  logic        ret_rdwen, ret_rdfpu;
  logic        oitf_empty;

  e203_exu_oitf #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .dis_ena(dis_ena), .dis_ready(dis_ready),
    .disp_i_rdwen(disp_i_rdwen), .disp_i_rdfpu(disp_i_rdfpu),
    .disp_i_rdidx(disp_i_rdidx), .disp_i_pc(disp_i_pc), .dis_ptr(dis_ptr),
    .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en),
    .disp_i_rs1fpu(disp_i_rs1fpu), .disp_i_rs2fpu(disp_i_rs2fpu),
    .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx),
    .oitfrd_match_disprs1(oitfrd_match_disprs1),
    .oitfrd_match_disprs2(oitfrd_match_disprs2),
    .oitfrd_match_disprd(oitfrd_match_disprd),
    .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdidx(ret_rdidx), .ret_pc(ret_pc),
    .ret_rdwen(ret_rdwen), .ret_rdfpu(ret_rdfpu),
    .oitf_empty(oitf_empty)
  );

  always #5 clk = ~clk;

  localparam int F_RDY = 0, F_EMPTY = 1, F_DPTR = 2, F_RPTR = 3, F_RIDX = 4,
                 F_RPC = 5, F_RWEN = 6, F_RFPU = 7, F_M1 = 8, F_M2 = 9, F_MRD = 10;

  typedef struct {
    string       name;
    int          f;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic logic [31:0] actual(input int f);
    case (f)
      F_RDY:   return {31'd0, dis_ready};
      F_EMPTY: return {31'd0, oitf_empty};
      F_DPTR:  return {27'd0, dis_ptr};
      F_RPTR:  return {27'd0, ret_ptr};
      F_RIDX:  return {27'd0, ret_rdidx};
      F_RPC:   return ret_pc;
      F_RWEN:  return {31'd0, ret_rdwen};
      F_RFPU:  return {31'd0, ret_rdfpu};
      F_M1:    return {31'd0, oitfrd_match_disprs1};
      F_M2:    return {31'd0, oitfrd_match_disprs2};
      F_MRD:   return {31'd0, oitfrd_match_disprd};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic string fname(input int f);
    case (f)
      F_RDY:   return "dis_ready";
      F_EMPTY: return "oitf_empty";
      F_DPTR:  return "dis_ptr";
      F_RPTR:  return "ret_ptr";
      F_RIDX:  return "ret_rdidx";
      F_RPC:   return "ret_pc";
      F_RWEN:  return "ret_rdwen";
      F_RFPU:  return "ret_rdfpu";
      F_M1:    return "match_rs1";
      F_M2:    return "match_rs2";
      F_MRD:   return "match_rd";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: every queued expectation is checked on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.f);
      n_checks++;
      if (a !== e.v) begin
        n_err++;
        $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", e.name, fname(e.f), a, e.v);
      end
    end
  end

  task automatic ex(input string n, input int f, input logic [31:0] v);
    sb.push_back('{n, f, v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    dis_ena = 1'b0; ret_ena = 1'b0;
    disp_i_rdwen = 1'b0; disp_i_rdfpu = 1'b0; disp_i_rdidx = 5'd0; disp_i_pc = 32'd0;
    disp_i_rs1en = 1'b0; disp_i_rs2en = 1'b0; disp_i_rs1fpu = 1'b0; disp_i_rs2fpu = 1'b0;
    disp_i_rs1idx = 5'd0; disp_i_rs2idx = 5'd0;
  endtask

  task automatic alloc(input logic [4:0] idx, input logic wen, input logic fpu,
                       input logic [31:0] pc);
    dis_ena = 1'b1; disp_i_rdidx = idx; disp_i_rdwen = wen; disp_i_rdfpu = fpu;
    disp_i_pc = pc;
  endtask

  task automatic rs1(input logic en, input logic [4:0] idx, input logic fpu);
    disp_i_rs1en = en; disp_i_rs1idx = idx; disp_i_rs1fpu = fpu;
  endtask

  task automatic exp_reset_state(input string n);
    ex(n, F_RDY, 32'd1);  ex(n, F_EMPTY, 32'd1); ex(n, F_DPTR, 32'd0);
    ex(n, F_RPTR, 32'd0); ex(n, F_RIDX, 32'd0);  ex(n, F_RPC, 32'd0);
    ex(n, F_RWEN, 32'd0); ex(n, F_RFPU, 32'd0);
    ex(n, F_M1, 32'd0);   ex(n, F_M2, 32'd0);    ex(n, F_MRD, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    tick();
    // Reset state, with sources enabled so a stale match would show.
    rs1(1'b1, 5'd0, 1'b0);
    disp_i_rdwen = 1'b1;
    exp_reset_state("reset");
    tick();
    rst = 1'b0;

    // Fill: rdidx 1..4, itags 0..3.
    for (int i = 0; i < 4; i++) begin
      idle_in();
      alloc(5'(i + 1), 1'b1, 1'b0, 32'h8000_0000 + 32'(4 * i));
      ex($sformatf("fill%0d", i), F_DPTR, 32'(i));
      ex($sformatf("fill%0d", i), F_RDY, 32'd1);
      ex($sformatf("fill%0d", i), F_EMPTY, (i == 0) ? 32'd1 : 32'd0);
      if (i > 0) begin
        ex($sformatf("fill%0d", i), F_RIDX, 32'd1);
        ex($sformatf("fill%0d", i), F_RPC, 32'h8000_0000);
      end
      tick();
    end
    // Fifth dispatch while full must be ignored.
    idle_in();
    alloc(5'd9, 1'b1, 1'b0, 32'h0000_0999);
    ex("full_dis", F_RDY, 32'd0); ex("full_dis", F_EMPTY, 32'd0);
    ex("full_dis", F_DPTR, 32'd0);
    tick();
    idle_in();
    ex("full_after", F_RDY, 32'd0); ex("full_after", F_DPTR, 32'd0);
    ex("full_after", F_RPTR, 32'd0); ex("full_after", F_RIDX, 32'd1);
    tick();

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      idle_in();
      ret_ena = 1'b1;
      ex($sformatf("drain%0d", i), F_RPTR, 32'(i));
      ex($sformatf("drain%0d", i), F_RIDX, 32'(i + 1));
      ex($sformatf("drain%0d", i), F_RPC, 32'h8000_0000 + 32'(4 * i));
      ex($sformatf("drain%0d", i), F_RWEN, 32'd1);
      ex($sformatf("drain%0d", i), F_EMPTY, 32'd0);
      ex($sformatf("drain%0d", i), F_RDY, (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    // Retire while empty is ignored.
    idle_in();
    ret_ena = 1'b1;
    ex("ret_empty", F_EMPTY, 32'd1); ex("ret_empty", F_RPTR, 32'd0);
    ex("ret_empty", F_RDY, 32'd1);   ex("ret_empty", F_DPTR, 32'd0);
    tick();
    idle_in();
    ex("ret_empty2", F_EMPTY, 32'd1); ex("ret_empty2", F_RPTR, 32'd0);
    ex("ret_empty2", F_DPTR, 32'd0);
    tick();

    // Wrapped allocation.
    idle_in();
    alloc(5'd7, 1'b1, 1'b0, 32'h0000_0100);
    ex("wrap_alc", F_DPTR, 32'd0); ex("wrap_alc", F_EMPTY, 32'd1);
    tick();
    idle_in();
    alloc(5'd8, 1'b1, 1'b0, 32'h0000_0104);
    ex("wrap_next", F_DPTR, 32'd1); ex("wrap_next", F_EMPTY, 32'd0);
    ex("wrap_next", F_RPTR, 32'd0); ex("wrap_next", F_RIDX, 32'd7);
    ex("wrap_next", F_RPC, 32'h0000_0100);
    tick();

    // Simultaneous alloc + retire at occupancy 2.
    idle_in();
    alloc(5'd10, 1'b1, 1'b0, 32'h0000_0108);
    ret_ena = 1'b1;
    ex("sim2", F_DPTR, 32'd2); ex("sim2", F_RPTR, 32'd0);
    ex("sim2", F_RIDX, 32'd7); ex("sim2", F_RDY, 32'd1);
    tick();
    idle_in();
    alloc(5'd11, 1'b1, 1'b0, 32'h0000_010C);
    ex("sim2_after", F_RPTR, 32'd1); ex("sim2_after", F_RIDX, 32'd8);
    ex("sim2_after", F_DPTR, 32'd3); ex("sim2_after", F_EMPTY, 32'd0);
    tick();
    idle_in();
    alloc(5'd12, 1'b1, 1'b0, 32'h0000_0110);
    ex("fill_again", F_DPTR, 32'd0); ex("fill_again", F_RDY, 32'd1);
    tick();

    // Simultaneous at full: only the retire happens.
    idle_in();
    alloc(5'd13, 1'b1, 1'b0, 32'h0000_0114);
    ret_ena = 1'b1;
    ex("simfull", F_RDY, 32'd0); ex("simfull", F_RPTR, 32'd1);
    ex("simfull", F_RIDX, 32'd8); ex("simfull", F_DPTR, 32'd1);
    tick();
    idle_in();
    rs1(1'b1, 5'd10, 1'b0);
    ex("simfull_after", F_RDY, 32'd1); ex("simfull_after", F_RPTR, 32'd2);
    ex("simfull_after", F_RIDX, 32'd10); ex("simfull_after", F_RPC, 32'h0000_0108);
    ex("simfull_after", F_DPTR, 32'd1); ex("simfull_after", F_M1, 32'd1);
    tick();

    // Reset pulse in the middle of a cycle with three entries valid.
    idle_in();
    rs1(1'b1, 5'd10, 1'b0);
    exp_reset_state("midrst");
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Hazard checks against entry rdidx=5, rdwen=1, rdfpu=0.
    idle_in();
    alloc(5'd5, 1'b1, 1'b0, 32'h0000_0200);
    ex("post_rst_alc", F_DPTR, 32'd0); ex("post_rst_alc", F_EMPTY, 32'd1);
    tick();
    idle_in();
    rs1(1'b1, 5'd5, 1'b0);
    disp_i_rs2en = 1'b1; disp_i_rs2idx = 5'd5; disp_i_rs2fpu = 1'b1;
    disp_i_rdwen = 1'b1; disp_i_rdidx = 5'd5; disp_i_rdfpu = 1'b0;
    ex("haz1", F_M1, 32'd1); ex("haz1", F_M2, 32'd0); ex("haz1", F_MRD, 32'd1);
    ex("haz1", F_RIDX, 32'd5); ex("haz1", F_RPC, 32'h0000_0200);
    tick();
    idle_in();
    rs1(1'b1, 5'd5, 1'b1);
    disp_i_rs2en = 1'b1; disp_i_rs2idx = 5'd5; disp_i_rs2fpu = 1'b0;
    disp_i_rdwen = 1'b0; disp_i_rdidx = 5'd5;
    ex("haz2", F_M1, 32'd0); ex("haz2", F_M2, 32'd1); ex("haz2", F_MRD, 32'd0);
    tick();
    idle_in();
    rs1(1'b0, 5'd5, 1'b0);
    ex("haz3", F_M1, 32'd0);
    tick();
    // Retiring entry still matches; the new rdwen=0 entry is not yet visible.
    idle_in();
    alloc(5'd5, 1'b0, 1'b0, 32'h0000_0204);
    ret_ena = 1'b1;
    rs1(1'b1, 5'd5, 1'b0);
    ex("haz_ret", F_M1, 32'd1); ex("haz_ret", F_RPTR, 32'd0);
    tick();
    idle_in();
    rs1(1'b1, 5'd5, 1'b0);
    disp_i_rdwen = 1'b1; disp_i_rdidx = 5'd5; disp_i_rdfpu = 1'b0;
    ex("haz_after", F_M1, 32'd0); ex("haz_after", F_MRD, 32'd0);
    ex("haz_after", F_RPTR, 32'd1); ex("haz_after", F_RWEN, 32'd0);
    ex("haz_after", F_RIDX, 32'd5); ex("haz_after", F_RPC, 32'h0000_0204);
    tick();
    // Allocating entry does not match in its own cycle.
    idle_in();
    alloc(5'd6, 1'b1, 1'b1, 32'h0000_0208);
    rs1(1'b1, 5'd6, 1'b1);
    ex("haz_alc", F_M1, 32'd0); ex("haz_alc", F_DPTR, 32'd2);
    tick();
    idle_in();
    rs1(1'b1, 5'd6, 1'b1);
    ex("haz_alc_next", F_M1, 32'd1); ex("haz_alc_next", F_RFPU, 32'd0);
    ex("haz_alc_next", F_RPTR, 32'd1);
    tick();

    idle_in();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
